// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: JTAG initiator that walks an external TAP through
// IR/DR scans and returns the TDO bits captured while in Shift.
module jtag_host_shifter #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_tlr,
    input  logic                cmd_ir,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    localparam int BIT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        S_INIT_TLR, S_IDLE, S_TLR, S_HDR, S_SHIFT, S_TRL, S_RSP
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          cell_q;
    logic [BIT_W-1:0]    bit_q;
    logic [BIT_W-1:0]    last_q;
    logic                ir_q;
    logic [MAX_BITS-1:0] data_q;
    logic [MAX_BITS-1:0] tdo_q;
    logic                tck_q;
    logic                tms_q;
    logic                tdi_q;
    logic                ready_q;
    logic                valid_q;

    logic [LEN_W-1:0]    len_d;
    logic                in_cell_d;
    logic                rise_d;
    logic                fall_d;
    logic [2:0]          hdr_last_d;

    always_comb begin
        len_d      = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
        in_cell_d  = state_q inside {S_INIT_TLR, S_TLR, S_HDR, S_SHIFT, S_TRL};
        rise_d     = in_cell_d && (cnt_q == CNT_LAST) && !tck_q;
        fall_d     = in_cell_d && (cnt_q == CNT_LAST) && tck_q;
        hdr_last_d = ir_q ? 3'd3 : 3'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT_TLR;
            cnt_q   <= '0;
            cell_q  <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            ir_q    <= 1'b0;
            data_q  <= '0;
            tdo_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (in_cell_d)
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (rise_d) begin
                tck_q <= 1'b1;
                if (state_q == S_SHIFT)
                    tdo_q[bit_q] <= tdo;
            end
            if (fall_d)
                tck_q <= 1'b0;

            // Cell transitions happen on the falling edge: the start of the
            // next cell's low phase is where tms/tdi may change.
            unique case (state_q)
                S_INIT_TLR, S_TLR: if (fall_d) begin
                    tms_q <= (cell_q < 3'd4);
                    if (cell_q == 3'd5) begin
                        cell_q <= '0;
                        if (state_q == S_INIT_TLR) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RSP;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cell_q <= cell_q + 3'd1;
                    end
                end
                S_IDLE: if (cmd_valid && ready_q) begin
                    ready_q <= 1'b0;
                    ir_q    <= cmd_ir;
                    data_q  <= cmd_tdi;
                    tdo_q   <= '0;
                    cell_q  <= '0;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    last_q  <= BIT_W'(len_d - LEN_W'(1));
                    tdi_q   <= 1'b0;
                    if (cmd_tlr) begin
                        state_q <= S_TLR;
                        tms_q   <= 1'b1;
                    end else if (len_d == '0) begin
                        state_q <= S_RSP;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= S_HDR;
                        tms_q   <= 1'b1;
                    end
                end
                S_HDR: if (fall_d) begin
                    if (cell_q == hdr_last_d) begin
                        state_q <= S_SHIFT;
                        cell_q  <= '0;
                        tms_q   <= (last_q == '0);
                        tdi_q   <= data_q[0];
                    end else begin
                        cell_q  <= cell_q + 3'd1;
                        tms_q   <= ir_q && (cell_q == 3'd0);
                    end
                end
                S_SHIFT: if (fall_d) begin
                    if (bit_q == last_q) begin
                        state_q <= S_TRL;
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                    end else begin
                        bit_q   <= bit_q + BIT_W'(1);
                        tms_q   <= ((bit_q + BIT_W'(1)) == last_q);
                        tdi_q   <= data_q[1];
                        data_q  <= data_q >> 1;
                    end
                end
                S_TRL: if (fall_d) begin
                    if (cell_q == 3'd1) begin
                        state_q <= S_RSP;
                        cell_q  <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        cell_q  <= cell_q + 3'd1;
                        tms_q   <= 1'b0;
                    end
                end
                S_RSP: if (rsp_ready) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_tdo   = tdo_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: directed scans against a small TAP model; responses
// go through a scoreboard queue checked by an independent monitor.
module tb_jtag_host_shifter;
    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;
    localparam int TCK_DIV  = 2;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_tlr   = 1'b0;
    logic                cmd_ir    = 1'b0;
    logic [LEN_W-1:0]    cmd_len   = '0;
    logic [MAX_BITS-1:0] cmd_tdi   = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [MAX_BITS-1:0] rsp_tdo;
    logic                tck;
    logic                tms;
    logic                tdi;
    logic                tdo;

    always #5 clk = ~clk;

    jtag_host_shifter #(
        .MAX_BITS(MAX_BITS),
        .LEN_W   (LEN_W),
        .TCK_DIV (TCK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_tlr  (cmd_tlr),
        .cmd_ir   (cmd_ir),
        .cmd_len  (cmd_len),
        .cmd_tdi  (cmd_tdi),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_tdo  (rsp_tdo),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    // TAP model: 4-bit IR capturing 0001, 8-bit DR loopback register
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
    } tap_t;

    tap_t       tap     = TLR;
    logic [7:0] dr_sr   = 8'h3C;
    logic [3:0] ir_sr   = 4'h0;
    logic [3:0] ir      = 4'hF;
    logic       tdo_one = 1'b0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PAUDR;
            PAUDR: return m ? EX2DR : PAUDR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAUIR;
            PAUIR: return m ? EX2IR : PAUIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            CAPIR:   ir_sr <= 4'b0001;
            SHIR:    ir_sr <= {tdi, ir_sr[3:1]};
            UPIR:    ir    <= ir_sr;
            SHDR:    dr_sr <= {tdi, dr_sr[7:1]};
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    assign tdo = tdo_one ? 1'b1 : ((tap == SHIR) ? ir_sr[0] : dr_sr[0]);

    // Edge logger: tms/tdi seen at each tck rise, sampled on clk falling edge
    logic tck_prev = 1'b0;
    int   edges    = 0;
    logic tms_log [0:1023];
    logic tdi_log [0:1023];

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            if (edges < 1024) begin
                tms_log[edges] = tms;
                tdi_log[edges] = tdi;
            end
            edges++;
        end
        tck_prev = tck;
    end

    function automatic logic [63:0] bits_of(logic sel_tdi, int base, int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++)
            v[i] = sel_tdi ? tdi_log[base+i] : tms_log[base+i];
        return v;
    endfunction

    // Scoreboard
    logic [MAX_BITS-1:0] exp_q [$];
    int rsp_seen = 0;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: actual %0h required none", rsp_tdo);
            end else begin
                check("rsp_tdo", 64'(rsp_tdo), 64'(exp_q.pop_front()));
            end
            rsp_seen++;
        end
    end

    task automatic send(input logic t, input logic i, input int len,
                        input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        exp_q.push_back(e);
        cmd_tlr   = t;
        cmd_ir    = i;
        cmd_len   = LEN_W'(len);
        cmd_tdi   = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_drop", 64'(cmd_ready), 64'd0);
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_seen < target) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: actual none required response");
        end
    endtask

    task automatic scan(input logic t, input logic i, input int len,
                        input logic [31:0] d, input logic [31:0] e, output int base);
        int n;
        base = edges;
        n    = rsp_seen;
        send(t, i, len, d, e);
        wait_rsp(n + 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        int bad;
        int e0;

        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_tdo", 64'(rsp_tdo), 64'd0);
        reset = 1'b0;
        base  = edges;
        repeat (23) @(negedge clk);
        check("init_ready_early", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("init_ready", 64'(cmd_ready), 64'd1);
        check("init_edges", 64'(edges - base), 64'd6);
        check("init_tms", bits_of(1'b0, base, 6), 64'h1F);
        check("init_tap", 64'(tap), 64'(RTI));

        scan(1'b0, 1'b0, 8, 32'hA5, 32'h3C, base);
        check("dr_edges", 64'(edges - base), 64'd13);
        check("dr_tms", bits_of(1'b0, base, 13), 64'h0C01);
        check("dr_tdi", bits_of(1'b1, base, 13), 64'h0528);
        check("dr_model", 64'(dr_sr), 64'hA5);
        check("dr_tap", 64'(tap), 64'(RTI));

        scan(1'b0, 1'b1, 4, 32'h2, 32'h1, base);
        check("ir_edges", 64'(edges - base), 64'd10);
        check("ir_hdr_tms", bits_of(1'b0, base, 4), 64'h3);
        check("ir_tms", bits_of(1'b0, base, 10), 64'h183);
        check("ir_model", 64'(ir), 64'h2);
        check("ir_tap", 64'(tap), 64'(RTI));

        rsp_ready = 1'b0;
        base = edges;
        send(1'b0, 1'b0, 8, 32'h0F, 32'hA5);
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 64'(rsp_valid), 64'd1);
        check("bp_edges", 64'(edges - base), 64'd13);
        e0  = edges;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_tdo !== 32'hA5 || cmd_ready || tck)
                bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_no_tck", 64'(edges - e0), 64'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("bp_post_valid", 64'(rsp_valid), 64'd0);
        check("bp_post_ready", 64'(cmd_ready), 64'd1);

        scan(1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'h0, base);
        check("len0_edges", 64'(edges - base), 64'd0);

        tdo_one = 1'b1;
        scan(1'b0, 1'b0, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, base);
        check("len32_edges", 64'(edges - base), 64'd37);
        check("len32_tms", bits_of(1'b0, base, 37), 64'h0000_000C_0000_0001);
        check("len32_tdi", bits_of(1'b1, base, 37), 64'h0000_0007_FFFF_FFF8);
        scan(1'b0, 1'b0, 63, 32'h0, 32'hFFFF_FFFF, base);
        check("clamp_edges", 64'(edges - base), 64'd37);
        tdo_one = 1'b0;

        scan(1'b1, 1'b1, 5, 32'h3, 32'h0, base);
        check("tlr_edges", 64'(edges - base), 64'd6);
        check("tlr_tms", bits_of(1'b0, base, 6), 64'h1F);
        check("tlr_tap", 64'(tap), 64'(RTI));

        base = edges;
        send(1'b0, 1'b0, 32, 32'h0, 32'h0);
        n = 0;
        while ((edges - base < 10 || !tck) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_in_shift", 64'(tck && (edges - base >= 10)), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_tck", 64'(tck), 64'd0);
        check("mid_tms", 64'(tms), 64'd1);
        check("mid_valid", 64'(rsp_valid), 64'd0);
        check("mid_ready", 64'(cmd_ready), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = edges;
        repeat (24) @(negedge clk);
        check("rerun_edges", 64'(edges - base), 64'd6);
        check("rerun_tms", bits_of(1'b0, base, 6), 64'h1F);
        check("rerun_tap", 64'(tap), 64'(RTI));
        check("rerun_ready", 64'(cmd_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_host_shifter.md
Name: jtag_host_shifter

Overview:
- JTAG initiator: generates TCK/TMS/TDI from the system clock and walks an external TAP through IR or DR scans.
- Designed to drive the GPIO scan-chain TAP from an FPGA-side controller or a test harness.
- Command interface: one scan request per handshake, carrying IR/DR select, bit count and TDI payload.
- Returns the TDO bits captured during the Shift state.

Parameters:
- MAX_BITS, 32, maximum scan length in bits; also the width of cmd_tdi and rsp_tdo.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_BITS.
- TCK_DIV, 2, clk cycles per TCK half-period; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_tlr  input  1  1 = Test-Logic-Reset sequence only; cmd_ir, cmd_len and cmd_tdi are ignored.
- cmd_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  LEN_W  number of bits to shift, 0..MAX_BITS.
- cmd_tdi  input  MAX_BITS  shift data, bit 0 shifted first.
- rsp_valid  output  1  scan result available.
- rsp_ready  input  1  result consumed.
- rsp_tdo  output  MAX_BITS  captured TDO; the first bit captured is in bit 0; bits >= len read 0.
- tck  output  1  JTAG clock; idles low.
- tms  output  1  JTAG mode select.
- tdi  output  1  JTAG data to the TAP.
- tdo  input  1  JTAG data from the TAP; already synchronous to tck.

Behaviour:
- Reset values:
  - tck=0, tms=1, tdi=0.
  - cmd_ready=0, rsp_valid=0, rsp_tdo=0.
  - State = INIT_TLR.
- Bit cell: one TCK period = 2*TCK_DIV clk cycles.
  - tms and tdi change only at the start of the low phase.
  - tck rises after TCK_DIV cycles.
  - tdo is sampled on the clk edge that drives tck high.
  - tck falls after another TCK_DIV cycles.
  - All outputs are registered.
- States: INIT_TLR, IDLE, TLR, HDR, SHIFT, TRL, RSP.
- INIT_TLR (entered from reset):
  - 5 cells with TMS=1, then 1 cell with TMS=0 (TAP ends in Run-Test/Idle).
  - Then go to IDLE.
- IDLE:
  - cmd_ready=1, tck held low, tms=0.
  - Accept on cmd_valid && cmd_ready: latch all cmd_* fields and drop cmd_ready the next cycle.
  - cmd_tlr=1 -> TLR.
  - cmd_len=0 -> RSP directly, rsp_tdo=0, no TCK pulses.
  - Otherwise -> HDR.
- TLR: same TMS pattern as INIT_TLR, then RSP with rsp_tdo=0.
- HDR: TMS header cells.
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0 (adds Select-IR).
  - tdi=0 during HDR.
- SHIFT: cmd_len cells.
  - tdi = cmd_tdi[i] in cell i.
  - TMS=0 in every cell except the last, which has TMS=1 (Exit1).
  - TDO sampled in cell i is stored in rsp_tdo[i].
- TRL: cells TMS=1 (Update), then TMS=0 (Run-Test/Idle); tdi=0. Then RSP.
- RSP:
  - rsp_valid=1 and rsp_tdo stable until rsp_valid && rsp_ready.
  - rsp_valid drops the next cycle; return to IDLE; cmd_ready=1 that cycle.
- Throughput: no new command is accepted while rsp_valid=1 (cmd_ready=0 from acceptance through the response handshake).
- Out-of-range length: cmd_len > MAX_BITS is clamped to MAX_BITS.
- Reset mid-scan: outputs return to reset values immediately and the INIT_TLR sequence reruns; any pending response is lost.
- Cell counter and bit index wrap-free: the bit index is never larger than MAX_BITS-1.
- tms is held at its last driven value between the end of a cell and the next state; after TRL it is 0.

Test Plan:
- Reset release, TCK_DIV=2:
  - Exactly 6 tck rising edges within 24 clk cycles.
  - TMS sampled at those edges = 1,1,1,1,1,0.
  - cmd_ready rises on the following cycle.
- DR scan, len=8, cmd_tdi=0xA5, tdo driven from an 8-bit loopback shift register preloaded with 0x3C:
  - TMS at the rising edges = 1,0,0, then 0 x7, 1, then 1,0.
  - TDI during shift = 1,0,1,0,0,1,0,1 (LSB first).
  - rsp_tdo=0x3C.
- IR scan, len=4, cmd_tdi=0x2 against the GPIO TAP model:
  - Header TMS = 1,1,0,0.
  - Model IR = 0x2 afterwards.
  - rsp_tdo[1:0]=2'b01 (standard IR capture).
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid:
  - rsp_valid and rsp_tdo stable.
  - cmd_ready=0, no tck activity.
  - Then one-cycle handshake, cmd_ready=1 on the next cycle.
- Edge lengths:
  - len=0 -> rsp_valid with 0 tck edges and rsp_tdo=0.
  - len=MAX_BITS=32, cmd_tdi=0xFFFFFFFF against a tdo=1 stub -> rsp_tdo=0xFFFFFFFF, exactly 32+3+2 tck edges.
- Reset asserted in the middle of SHIFT:
  - tck=0 and tms=1 asynchronously.
  - rsp_valid=0.
  - INIT_TLR pattern reappears after release.
